// File: rtl/cbus_arbiter_pkg.sv
// Local helpers for the CBus arbiter: index sizing and modulo increment that
// stays correct for non-power-of-two master counts.
package cbus_arbiter_pkg;

   function automatic int unsigned idx_w(input int unsigned n);
      return (n < 32'd2) ? 32'd1 : $clog2(n);
   endfunction

   function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
      return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
   endfunction

endpackage

// File: rtl/common_pkg.sv
// Shared CBus transaction types used by the bus converters, arbiters and
// memory/AXI bridge ports.
package common;

   typedef struct packed {
      logic        valid;
      logic        is_write;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [3:0]  strobe;
      logic [31:0] data;
      logic [7:0]  len;
   } cbus_req_t;

   typedef struct packed {
      logic        ready;
      logic        last;
      logic [31:0] data;
   } cbus_resp_t;

endpackage

// File: rtl/cbus_arbiter_rr_select.sv
// Round-robin picker: returns the first set bit of valid_i scanning from ptr_i
// upwards with wrap-around. Purely combinational.
module rr_select
   import cbus_arbiter_pkg::*;
#(
   parameter int unsigned N = 2,
   parameter int unsigned W = idx_w(N)
) (
   input  logic [N-1:0] valid_i,
   input  logic [W-1:0] ptr_i,
   output logic         any_o,
   output logic [W-1:0] sel_o
);

   function automatic logic [W-1:0] rot(input logic [W-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= int'(N)) begin
         s = s - int'(N);
      end else begin
         s = s;
      end
      return W'(s);
   endfunction

   // Scan from furthest offset down so the closest valid master to ptr wins.
   always_comb begin
      any_o = |valid_i;
      sel_o = ptr_i;
      for (int k = int'(N) - 1; k >= 0; k--) begin
         sel_o = valid_i[rot(ptr_i, k)] ? rot(ptr_i, k) : sel_o;
      end
   end

endmodule

// File: rtl/cbus_arbiter.sv
// Round-robin arbiter multiplexing NUM_INPUTS CBus masters onto one slave port,
// one transaction in flight; the grant is held until the final beat is accepted.
module cbus_arbiter
   import common::*;
   import cbus_arbiter_pkg::*;
#(
   parameter int unsigned NUM_INPUTS = 2
) (
   input  logic       clk,
   input  logic       resetn,
   input  cbus_req_t  ireqs  [NUM_INPUTS],
   output cbus_resp_t iresps [NUM_INPUTS],
   output cbus_req_t  oreq,
   input  cbus_resp_t oresp
);

   localparam int unsigned IDX_W = idx_w(NUM_INPUTS);

   logic                  busy_q, busy_d;
   logic [IDX_W-1:0]      index_q, index_d;
   logic [IDX_W-1:0]      ptr_q, ptr_d;
   logic [NUM_INPUTS-1:0] valid_s;
   logic                  any_s;
   logic [IDX_W-1:0]      sel_s;

   always_comb begin
      valid_s = '0;
      for (int i = 0; i < int'(NUM_INPUTS); i++) begin
         valid_s[i] = ireqs[i].valid;
      end
   end

   rr_select #(
      .N (NUM_INPUTS),
      .W (IDX_W)
   ) u_rr_select (
      .valid_i (valid_s),
      .ptr_i   (ptr_q),
      .any_o   (any_s),
      .sel_o   (sel_s)
   );

   // Request valids only matter while idle; once busy, only ready && last releases.
   always_comb begin
      busy_d  = busy_q;
      index_d = index_q;
      ptr_d   = ptr_q;
      if (!busy_q) begin
         if (any_s) begin
            busy_d  = 1'b1;
            index_d = sel_s;
         end else begin
            busy_d  = 1'b0;
         end
      end else if (oresp.ready && oresp.last) begin
         busy_d = 1'b0;
         ptr_d  = IDX_W'(wrap_inc(32'(index_q), NUM_INPUTS));
      end else begin
         busy_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         busy_q  <= 1'b0;
         index_q <= '0;
         ptr_q   <= '0;
      end else begin
         busy_q  <= busy_d;
         index_q <= index_d;
         ptr_q   <= ptr_d;
      end
   end

   // Pure pass-through muxing; nothing from oresp reaches oreq.
   always_comb begin
      oreq = '0;
      for (int i = 0; i < int'(NUM_INPUTS); i++) begin
         iresps[i] = '0;
         if (busy_q && (index_q == IDX_W'(i))) begin
            oreq      = ireqs[i];
            iresps[i] = oresp;
         end else begin
            iresps[i] = '0;
         end
      end
   end

endmodule

// File: doc/cbus_arbiter.md
# cbus_arbiter

Multiplexes several CBus masters onto one CBus slave port. Typically the instruction-side and data-side CBus channels, which come out of the IBus/DBus-to-CBus converters, share this arbiter. It feeds the single memory or AXI-bridge port. Arbitration is round-robin and one transaction is in flight at a time. The granted master owns the output until its final beat is accepted.

## Interface

Parameters:
- `NUM_INPUTS`, default 2: number of CBus masters. Legal range is 2..8.

Ports:
- `clk`  in  1: the single clock.
- `resetn`  in  1: reset, asynchronous and active-low.
- `ireqs`  in  `cbus_req_t [NUM_INPUTS]`: master requests. Fields are `valid`, `is_write`, `size`, `addr`, `strobe`, `data`, `len`.
- `iresps`  out  `cbus_resp_t [NUM_INPUTS]`: per-master responses. Fields are `ready`, `last`, `data`.
- `oreq`  out  `cbus_req_t`: request to the shared slave.
- `oresp`  in  `cbus_resp_t`: response from the shared slave.

## Operation

State:
- `busy` (1 bit).
- `index` (`$clog2(NUM_INPUTS)` bits): the granted master.
- `ptr` (same width as `index`): the highest-priority master for the next arbitration.

IDLE (`busy=0`):
- `oreq` is all-zero.
- Every `iresps[i]` is all-zero.
- If any `ireqs[i].valid` is 1, select the first valid master scanning `ptr`, `ptr+1`, … modulo `NUM_INPUTS`.
- On the next edge: `index` ← that master, `busy` ← 1.

BUSY (`busy=1`):
- `oreq` = `ireqs[index]`, passed through combinationally.
- `iresps[index]` = `oresp`; all other `iresps` are all-zero.
- On an edge where `oresp.ready && oresp.last`:
  - `busy` ← 0.
  - `ptr` ← `index+1` modulo `NUM_INPUTS`. For a non-power-of-2 `NUM_INPUTS`, `ptr` wraps explicitly to 0.
- Otherwise stay BUSY. `ireqs` valid levels are ignored for arbitration.

Master obligations:
- Hold `valid` and all request fields stable from assertion until its `last` beat is accepted. The arbiter does not buffer.
- If a granted master drops `valid` early, the arbiter still stays BUSY until `ready && last`. `oreq.valid` simply follows the input. This is a protocol violation; verification flags it with an assertion and does not treat it as legal stimulus.

Other rules:
- Non-granted masters never see `ready`. Their requests wait unchanged.
- Beats with `ready=1, last=0` are forwarded to the granted master only; state does not change.

Reset:
- Asserting `resetn` low (asynchronous) immediately forces `busy=0`, `index=0`, `ptr=0`.
- All outputs are therefore all-zero, including mid-burst. The slave is responsible for its own reset.

## Timing

- Grant latency: the `valid` edge is seen in IDLE, and `oreq.valid` is asserted one cycle later.
- Release: `ready && last` in cycle N gives IDLE in N+1, with `oreq` all-zero. A new grant is visible in N+2.
  - Back-to-back transactions therefore have exactly one bubble cycle.
  - A single-beat transaction whose `ready && last` arrives in its first BUSY cycle is legal and releases on that edge.
- Response path: `oresp` to `iresps[index]` is purely combinational, with zero latency.
- Request path: `ireqs[index]` to `oreq` is purely combinational.
- No combinational path exists from `oresp` to `oreq`.

## Structure

- `cbus_req_t` and `cbus_resp_t` stay in the shared `common` package. No new shared types are needed.
- The local arbitration index width is derived from `NUM_INPUTS`.
- One combinational sub-module, `rr_select`:
  - Inputs: the valid vector and `ptr`.
  - Outputs: `any` and `sel` index.
  - Reusable by later arbiters.
- State update and output muxing live in `cbus_arbiter`.

## Test plan

1. Master 0 only, read, `len`=4, `addr`=0x8000_0000, slave gives `ready` on 4 consecutive cycles with `last` on the 4th:
   - `oreq` mirrors `ireqs[0]` from cycle 1.
   - `iresps[0]` sees 4 beats; `iresps[1]` stays zero.
   - IDLE the cycle after `last`.
2. Both masters assert `valid` in the same cycle after reset:
   - Master 0 is granted first.
   - Master 1 is granted two cycles after master 0's `last`, with one bubble cycle.
   - `ptr` ends at 0.
3. Both masters request continuously with single-beat transactions: grants alternate 0,1,0,1 over 8 transactions.
4. Single-beat write from master 1 with `ready` and `last` in the first BUSY cycle: releases the same edge and `ptr` becomes 0.
5. `resetn` driven low mid-burst on master 1's second beat: `oreq` and all `iresps` are zero in the same cycle. After release, master 0 is granted first.
6. Master 1 stalled by slave `ready=0` for 10 cycles while master 0 asserts `valid`: master 0 receives no `ready` and waits. Master 0 is granted only after master 1's `last`.
